servo_pwm_capture: RTL and testbench

Receive-side counterpart of the `servo` PWM driver: samples an external servo/RC PWM line on the 25 MHz `clk`, measures each high pulse and the rising-to-rising period in clock ticks, and flags out-of-range or lost signals. Also outputs a clamped `duty` word in the same units the `servo` driver accepts. This allows a captured command to drive `servo.duty` directly, and gives a loopback check of the driver.

---
 rtl/servo_pkg.sv | 21 ++
 rtl/servo_pwm_capture_sync_edge.sv | 34 +++
 rtl/servo_pwm_capture.sv | 126 ++++++++++++
 tb/tb_servo_pwm_capture.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Constants and types shared by the servo PWM driver and its capture block.
package servo_pkg;

   localparam int W        = 20;
   localparam int MIN_W    = 25000;    // 1 ms at 25 MHz
   localparam int MAX_W    = 50000;    // 2 ms
   localparam int CENTER_W = 37500;    // 1.5 ms, neutral position
   localparam int FRAME_W  = 500000;   // 20 ms frame

   typedef enum logic [1:0] {
      LOST = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } cap_state_t;

   // Inclusive range test on plain integers.
   function automatic logic in_range(input int v, input int lo, input int hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/servo_pwm_capture_sync_edge.sv
// Two-flop synchronizer for an asynchronous line, plus a previous-value flop
// for rise/fall detection. All flops share a reset value so a line already
// at that level when reset releases produces no edge.
module sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta;
   logic prev;

   // Synchronizer chain and one-sample history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         sync <= RST_VAL;
         prev <= RST_VAL;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;
   assign fall = ~sync & prev;

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo/RC PWM receiver: measures high time and rise-to-rise period in clk
// ticks, range-checks both, and produces a clamped duty word for the driver.
module servo_pwm_capture #(
   parameter int W        = servo_pkg::W,
   parameter int MIN_W    = servo_pkg::MIN_W,
   parameter int MAX_W    = servo_pkg::MAX_W,
   parameter int CENTER_W = servo_pkg::CENTER_W,
   parameter int MAX_HIGH = 75000,
   parameter int PER_MIN  = 400000,
   parameter int PER_MAX  = 600000,
   parameter int TIMEOUT  = 1000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pwm_in,
   output logic [W-1:0] width,
   output logic         width_valid,
   output logic         width_ok,
   output logic [W-1:0] period,
   output logic         period_valid,
   output logic         period_ok,
   output logic [W-1:0] duty,
   output logic         lost
);

   import servo_pkg::*;

   cap_state_t   state;
   logic [W-1:0] high_cnt;
   logic [W-1:0] per_cnt;
   logic [W-1:0] duty_next;
   logic         sync;
   logic         rise;
   logic         fall;

   sync_edge #(.RST_VAL(1'b1)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (pwm_in),
      .sync (sync),
      .rise (rise),
      .fall (fall)
   );

   function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Clamp the running high count into the driver's legal duty range.
   always_comb begin
      duty_next = high_cnt;
      if (high_cnt < W'(MIN_W))
         duty_next = W'(MIN_W);
      else if (high_cnt > W'(MAX_W))
         duty_next = W'(MAX_W);
   end

   // Tracking FSM with its counters and registered outputs.
   // Counters restart at 1 on a rise because the rise cycle itself is the
   // first high sample and the first tick of the new period; this makes an
   // N-sample pulse read N and rises N edges apart read N.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= LOST;
         high_cnt     <= '0;
         per_cnt      <= '0;
         width        <= '0;
         width_ok     <= 1'b0;
         width_valid  <= 1'b0;
         period       <= '0;
         period_ok    <= 1'b0;
         period_valid <= 1'b0;
         duty         <= W'(CENTER_W);
         lost         <= 1'b1;
      end else begin
         width_valid  <= 1'b0;
         period_valid <= 1'b0;
         if (state != LOST)
            per_cnt <= sat_inc(per_cnt);
         case (state)
            LOST: begin
               if (rise) begin
                  high_cnt <= W'(1);
                  per_cnt  <= W'(1);
                  state    <= HIGH;
               end
            end
            HIGH: begin
               if (fall) begin
                  width       <= high_cnt;
                  width_ok    <= in_range(32'(high_cnt), MIN_W, MAX_W);
                  duty        <= duty_next;
                  width_valid <= 1'b1;
                  lost        <= 1'b0;
                  state       <= LOW;
               end else if (high_cnt >= W'(MAX_HIGH - 1)) begin
                  // this sample would bring the count to MAX_HIGH: stuck high
                  state <= LOST;
                  lost  <= 1'b1;
               end else if (sync) begin
                  high_cnt <= sat_inc(high_cnt);
               end
            end
            LOW: begin
               // a rise wins over a simultaneous timeout
               if (rise) begin
                  period       <= per_cnt;
                  period_ok    <= in_range(32'(per_cnt), PER_MIN, PER_MAX);
                  period_valid <= 1'b1;
                  high_cnt     <= W'(1);
                  per_cnt      <= W'(1);
                  state        <= HIGH;
               end else if (per_cnt >= W'(TIMEOUT - 1)) begin
                  state <= LOST;
                  lost  <= 1'b1;
               end
            end
            default: begin
               state <= LOST;
               lost  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Directed + randomized bench for servo_pwm_capture with time constants
// scaled down by 250 so whole frames fit in a short run.
module tb_servo_pwm_capture;

   localparam int W        = 20;
   localparam int MIN_W    = 100;
   localparam int MAX_W    = 200;
   localparam int CENTER_W = 150;
   localparam int MAX_HIGH = 300;
   localparam int PER_MIN  = 1600;
   localparam int PER_MAX  = 2400;
   localparam int TIMEOUT  = 4000;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         pwm_in = 1'b1;
   logic [W-1:0] width;
   logic         width_valid;
   logic         width_ok;
   logic [W-1:0] period;
   logic         period_valid;
   logic         period_ok;
   logic [W-1:0] duty;
   logic         lost;

   int total = 0;
   int bad   = 0;

   // strobed values seen on the outputs
   int got_w[$], got_wok[$], got_duty[$], got_p[$], got_pok[$];
   // expected pulse widths and periods, in the order they should appear
   int exp_w[$], exp_p[$];
   bit tracking = 1'b0;
   int last_per = 0;

   servo_pwm_capture #(
      .W(W), .MIN_W(MIN_W), .MAX_W(MAX_W), .CENTER_W(CENTER_W),
      .MAX_HIGH(MAX_HIGH), .PER_MIN(PER_MIN), .PER_MAX(PER_MAX), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pwm_in       (pwm_in),
      .width        (width),
      .width_valid  (width_valid),
      .width_ok     (width_ok),
      .period       (period),
      .period_valid (period_valid),
      .period_ok    (period_ok),
      .duty         (duty),
      .lost         (lost)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (width_valid) begin
         got_w.push_back(int'(width));
         got_wok.push_back(int'(width_ok));
         got_duty.push_back(int'(duty));
      end
      if (period_valid) begin
         got_p.push_back(int'(period));
         got_pok.push_back(int'(period_ok));
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int model_duty(input int w);
      if (w < MIN_W) return MIN_W;
      if (w > MAX_W) return MAX_W;
      return w;
   endfunction

   // Compare everything strobed since the last call with the model, then clear.
   task automatic check_q(input string tag);
      chk({tag, ":n_width"}, got_w.size(), exp_w.size());
      chk({tag, ":n_period"}, got_p.size(), exp_p.size());
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
         chk({tag, ":width"}, got_w[i], exp_w[i]);
         chk({tag, ":width_ok"}, got_wok[i], int'(exp_w[i] >= MIN_W && exp_w[i] <= MAX_W));
         chk({tag, ":duty"}, got_duty[i], model_duty(exp_w[i]));
      end
      for (int i = 0; i < exp_p.size() && i < got_p.size(); i++) begin
         chk({tag, ":period"}, got_p[i], exp_p[i]);
         chk({tag, ":period_ok"}, got_pok[i], int'(exp_p[i] >= PER_MIN && exp_p[i] <= PER_MAX));
      end
      got_w.delete(); got_wok.delete(); got_duty.delete();
      got_p.delete(); got_pok.delete();
      exp_w.delete(); exp_p.delete();
   endtask

   // One frame: hi samples high, rise-to-rise distance per. Called and
   // returns 1 time unit after a rising clk edge.
   task automatic frame(input int hi, input int per);
      if (tracking) exp_p.push_back(last_per);
      exp_w.push_back(hi);
      pwm_in = 1'b1;
      tick(hi);
      pwm_in = 1'b0;
      tick(per - hi);
      tracking = 1'b1;
      last_per = per;
   endtask

   int dir_hi[8]  = '{80, 240, 150, 100, 200, 99, 201, 299};
   int dir_per[8] = '{2000, 2000, 1200, 1600, 2400, 1599, 2401, 2000};

   initial begin
      // reset with the line already high
      rst = 1'b1; pwm_in = 1'b1;
      tick(4);
      chk("rst:width", int'(width), 0);
      chk("rst:period", int'(period), 0);
      chk("rst:width_ok", int'(width_ok), 0);
      chk("rst:period_ok", int'(period_ok), 0);
      chk("rst:strobes", int'({width_valid, period_valid}), 0);
      chk("rst:duty", int'(duty), CENTER_W);
      chk("rst:lost", int'(lost), 1);
      rst = 1'b0;
      tick(400);
      chk("hold_high:lost", int'(lost), 1);
      chk("hold_high:duty", int'(duty), CENTER_W);
      check_q("hold_high");

      // nominal frames
      pwm_in = 1'b0;
      tick(20);
      for (int i = 0; i < 3; i++) frame(150, 2000);
      chk("nominal:lost", int'(lost), 0);
      check_q("nominal");

      // directed boundaries and out-of-range cases
      for (int i = 0; i < 8; i++) frame(dir_hi[i], dir_per[i]);
      check_q("directed");

      // random frames
      for (int i = 0; i < 6; i++) begin
         int hi, per;
         hi  = $urandom_range(20, 290);
         per = $urandom_range(1000, 3000);
         frame(hi, per);
      end
      check_q("random");

      // stuck high: the rise still closes the previous period
      if (tracking) exp_p.push_back(last_per);
      pwm_in = 1'b1;
      tick(MAX_HIGH);
      pwm_in = 1'b0;
      tracking = 1'b0;
      tick(50);
      chk("stuck:lost", int'(lost), 1);
      check_q("stuck");
      frame(120, 2000);
      chk("after_stuck:lost", int'(lost), 0);
      check_q("after_stuck");

      // loss of signal after a valid pulse
      if (tracking) exp_p.push_back(last_per);
      exp_w.push_back(180);
      pwm_in = 1'b1;
      tick(180);
      pwm_in = 1'b0;
      tick(10);
      chk("pre_timeout:lost", int'(lost), 0);
      tick(TIMEOUT + 100);
      tracking = 1'b0;
      chk("timeout:lost", int'(lost), 1);
      chk("timeout:width", int'(width), 180);
      chk("timeout:duty", int'(duty), 180);
      check_q("timeout");

      // reset in the middle of a pulse
      frame(150, 2000);
      if (tracking) exp_p.push_back(last_per);
      pwm_in = 1'b1;
      tick(80);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst:width", int'(width), 0);
      chk("mid_rst:period", int'(period), 0);
      chk("mid_rst:oks", int'({width_ok, period_ok}), 0);
      chk("mid_rst:duty", int'(duty), CENTER_W);
      chk("mid_rst:lost", int'(lost), 1);
      tick(2);
      rst = 1'b0;
      tick(78);
      pwm_in = 1'b0;
      tracking = 1'b0;
      tick(20);
      chk("post_rst:lost", int'(lost), 1);
      chk("post_rst:width", int'(width), 0);
      check_q("mid_rst");

      // fall-to-strobe latency and strobe width
      exp_w.push_back(150);
      pwm_in = 1'b1;
      tick(150);
      pwm_in = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("lat:edge1", int'(width_valid), 0);
      @(posedge clk); @(negedge clk);
      chk("lat:edge2", int'(width_valid), 0);
      @(posedge clk); @(negedge clk);
      chk("lat:edge3", int'(width_valid), 1);
      chk("lat:width", int'(width), 150);
      @(posedge clk); @(negedge clk);
      chk("lat:edge4", int'(width_valid), 0);
      @(posedge clk); #1;
      tick(10);
      chk("lat:lost", int'(lost), 0);
      check_q("latency");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
